// File: rtl/garage_slot_counter.sv
// Garage occupancy controller: debounced entry/exit sensors, gate sequencing,
// and a registered BCD free-slot count for the 7-segment decoder.

module gsc_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic evt
);
    localparam int CW = (DEBOUNCE_CYCLES < 1) ? 1 : $clog2(DEBOUNCE_CYCLES + 1);

    logic          s1, s2, filt, filt_q;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            filt   <= 1'b0;
            filt_q <= 1'b0;
            cnt    <= '0;
        end else begin
            s1     <= raw;
            s2     <= s1;
            filt_q <= filt;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                // Counter would reach the threshold on this edge: accept the new level.
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

    assign evt = filt & ~filt_q;
endmodule

module garage_slot_counter #(
    parameter int CAPACITY         = 9,
    parameter int DEBOUNCE_CYCLES  = 4,
    parameter int GATE_OPEN_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       entry_sensor,
    input  logic       exit_sensor,
    output logic [3:0] free_bcd,
    output logic       full,
    output logic       empty,
    output logic       gate_in_open,
    output logic       gate_out_open,
    output logic       reject
);
    localparam int NUM_SENSORS = 2;
    localparam int SEN_ENTRY   = 0;
    localparam int SEN_EXIT    = 1;
    localparam int TW          = $clog2(GATE_OPEN_CYCLES + 1);

    typedef enum logic [1:0] {IDLE, ENTRY_OPEN, EXIT_OPEN} state_t;

    logic [NUM_SENSORS-1:0] raw, evt;
    state_t                 state, state_nxt;
    logic [TW-1:0]          timer, timer_nxt;
    logic [3:0]             occ, occ_nxt;
    logic                   exit_ok, entry_ok, entry_rej;

    assign raw = {exit_sensor, entry_sensor};

    for (genvar g = 0; g < NUM_SENSORS; g++) begin : g_sen
        gsc_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk (clk),
            .rst (rst),
            .raw (raw[g]),
            .evt (evt[g])
        );
    end

    // Exit wins a tie; a simultaneous entry is dropped rather than queued.
    always_comb begin
        exit_ok   = (state == IDLE) & evt[SEN_EXIT] & ~empty;
        entry_ok  = (state == IDLE) & evt[SEN_ENTRY] & ~full & ~exit_ok;
        entry_rej = (state == IDLE) & evt[SEN_ENTRY] & full & ~exit_ok;
        state_nxt = state;
        timer_nxt = timer;
        occ_nxt   = occ;
        case (state)
            IDLE: begin
                if (exit_ok) begin
                    state_nxt = EXIT_OPEN;
                    timer_nxt = TW'(GATE_OPEN_CYCLES - 1);
                    occ_nxt   = occ - 4'd1;
                end else if (entry_ok) begin
                    state_nxt = ENTRY_OPEN;
                    timer_nxt = TW'(GATE_OPEN_CYCLES - 1);
                    occ_nxt   = occ + 4'd1;
                end
            end
            ENTRY_OPEN, EXIT_OPEN: begin
                if (timer == '0) state_nxt = IDLE;
                else             timer_nxt = timer - TW'(1);
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Display/status flags are taken from occ_nxt so they move with the count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            occ      <= '0;
            free_bcd <= 4'(CAPACITY);
            full     <= 1'b0;
            empty    <= 1'b1;
            reject   <= 1'b0;
        end else begin
            state    <= state_nxt;
            timer    <= timer_nxt;
            occ      <= occ_nxt;
            free_bcd <= 4'(CAPACITY) - occ_nxt;
            full     <= (occ_nxt == 4'(CAPACITY));
            empty    <= (occ_nxt == 4'd0);
            reject   <= entry_rej;
        end
    end

    always_comb begin
        gate_in_open  = 1'b0;
        gate_out_open = 1'b0;
        case (state)
            ENTRY_OPEN: gate_in_open  = 1'b1;
            EXIT_OPEN:  gate_out_open = 1'b1;
            default: ;
        endcase
    end
endmodule
